// File: rtl/cla_mp_sequencer_pkg.sv
// Shared types and the 4-bit lookahead helper for the multi-precision add/subtract sequencer.
package cla_seq_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } seq_op_t;

    // Returns {group_generate, group_propagate, c3, c2, c1} for one 4-bit lookahead cell.
    function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic c0);
        logic c1;
        logic c2;
        logic c3;
        logic gg;
        logic gp;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp = &p;
        return {gg, gp, c3, c2, c1};
    endfunction

endpackage

// File: rtl/cla_mp_sequencer_cla.sv
// Purely combinational 32-bit two-level carry-lookahead adder shared by the sequencer.
module cla_mp_sequencer_cla
    import cla_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              carry_cin,
    output logic [WORD_W-1:0] sum_cla,
    output logic              carry_cla
);

    localparam int NUM_GRP = WORD_W / 4;

    logic [WORD_W-1:0]  g_s;
    logic [WORD_W-1:0]  p_s;
    logic [WORD_W-1:0]  c_s;
    logic [NUM_GRP-1:0] grp_g_s;
    logic [NUM_GRP-1:0] grp_p_s;
    logic [NUM_GRP-1:0] grp_c_s;
    logic [4:0]         cell_s;
    logic [4:0]         lo_s;
    logic [4:0]         hi_s;
    logic               mid_c_s;

    // Bit g/p, group g/p, then a second lookahead level over two blocks of four groups.
    always_comb begin
        g_s     = a & b;
        p_s     = a ^ b;
        grp_g_s = '0;
        grp_p_s = '0;
        c_s     = '0;
        cell_s  = '0;
        for (int j = 0; j < NUM_GRP; j++) begin
            cell_s     = cla4(g_s[4*j +: 4], p_s[4*j +: 4], 1'b0);
            grp_g_s[j] = cell_s[4];
            grp_p_s[j] = cell_s[3];
        end
        lo_s    = cla4(grp_g_s[3:0], grp_p_s[3:0], carry_cin);
        mid_c_s = lo_s[4] | (lo_s[3] & carry_cin);
        hi_s    = cla4(grp_g_s[7:4], grp_p_s[7:4], mid_c_s);
        grp_c_s = {hi_s[2:0], mid_c_s, lo_s[2:0], carry_cin};
        for (int j = 0; j < NUM_GRP; j++) begin
            cell_s          = cla4(g_s[4*j +: 4], p_s[4*j +: 4], grp_c_s[j]);
            c_s[4*j +: 4]   = {cell_s[2:0], grp_c_s[j]};
        end
        sum_cla   = p_s ^ c_s;
        carry_cla = hi_s[4] | (hi_s[3] & mid_c_s);
    end

endmodule

// File: rtl/cla_mp_sequencer.sv
// Wide add/subtract that walks one 32-bit CLA across NUM_WORDS words, LSW first, one word per clock.
module cla_mp_sequencer
    import cla_seq_pkg::*;
#(
    parameter int NUM_WORDS = 4,
    parameter int WORD_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_op,
    input  logic [WORD_W*NUM_WORDS-1:0] req_a,
    input  logic [WORD_W*NUM_WORDS-1:0] req_b,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [WORD_W*NUM_WORDS-1:0] resp_result,
    output logic                        resp_carry,
    output logic                        resp_overflow,
    output logic                        resp_zero,
    output logic                        busy
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    seq_state_t        state_r;
    seq_op_t           op_r;
    logic [IDX_W-1:0]  idx_r;
    logic              carry_r;
    logic [WORD_W-1:0] a_r      [NUM_WORDS];
    logic [WORD_W-1:0] b_r      [NUM_WORDS];
    logic [WORD_W-1:0] result_r [NUM_WORDS];

    logic [WORD_W-1:0] a_word_s;
    logic [WORD_W-1:0] b_mod_s;
    logic [WORD_W-1:0] sum_s;
    logic              carry_s;
    logic              other_nz_s;
    logic              zero_s;
    logic              overflow_s;

    // Word-select mux; subtract feeds the inverted b word with carry-in 1 from the accept.
    always_comb begin
        a_word_s = a_r[idx_r];
        b_mod_s  = b_r[idx_r] ^ {WORD_W{op_r == OP_SUB}};
    end

    cla_mp_sequencer_cla u_cla (
        .a         (a_word_s),
        .b         (b_mod_s),
        .carry_cin (carry_r),
        .sum_cla   (sum_s),
        .carry_cla (carry_s)
    );

    // Zero must include the word being written this cycle, not its stale register copy.
    always_comb begin
        other_nz_s = 1'b0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (IDX_W'(k) != idx_r) begin
                other_nz_s = other_nz_s | (|result_r[k]);
            end else begin
                other_nz_s = other_nz_s;
            end
        end
        zero_s     = ~(other_nz_s | (|sum_s));
        overflow_s = (a_word_s[WORD_W-1] == b_mod_s[WORD_W-1]) &&
                     (sum_s[WORD_W-1] != a_word_s[WORD_W-1]);
    end

    // Flatten the result words onto the response bus.
    always_comb begin
        resp_result = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            resp_result[k*WORD_W +: WORD_W] = result_r[k];
        end
    end

    // Sequencer FSM, operand capture, word write-back and flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            op_r          <= OP_ADD;
            idx_r         <= '0;
            carry_r       <= 1'b0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_carry    <= 1'b0;
            resp_overflow <= 1'b0;
            resp_zero     <= 1'b0;
            busy          <= 1'b0;
            for (int k = 0; k < NUM_WORDS; k++) begin
                a_r[k]      <= '0;
                b_r[k]      <= '0;
                result_r[k] <= '0;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        for (int k = 0; k < NUM_WORDS; k++) begin
                            a_r[k] <= req_a[k*WORD_W +: WORD_W];
                            b_r[k] <= req_b[k*WORD_W +: WORD_W];
                        end
                        op_r      <= seq_op_t'(req_op);
                        idx_r     <= '0;
                        carry_r   <= req_op;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_r[idx_r] <= sum_s;
                    carry_r         <= carry_s;
                    if (idx_r == LAST_IDX) begin
                        idx_r         <= '0;
                        resp_carry    <= carry_s;
                        resp_overflow <= overflow_s;
                        resp_zero     <= zero_s;
                        resp_valid    <= 1'b1;
                        state_r       <= S_DONE;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
                        state_r    <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    req_ready  <= 1'b1;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Randomized and directed checks of cla_mp_sequencer against a wide-integer reference model.
module tb_cla_mp_sequencer;

    localparam int NW = 4;
    localparam int W  = 32 * NW;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b1;
    logic         req_valid  = 1'b0;
    logic         req_op     = 1'b0;
    logic         resp_ready = 1'b0;
    logic [W-1:0] req_a      = '0;
    logic [W-1:0] req_b      = '0;
    logic         req_ready;
    logic         resp_valid;
    logic         resp_carry;
    logic         resp_overflow;
    logic         resp_zero;
    logic         busy;
    logic [W-1:0] resp_result;

    int errors_cnt = 0;
    int checks_cnt = 0;

    always #5 clk = ~clk;

    cla_mp_sequencer #(.NUM_WORDS(NW), .WORD_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_carry    (resp_carry),
        .resp_overflow (resp_overflow),
        .resp_zero     (resp_zero),
        .busy          (busy)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain (W+1)-bit unsigned and signed arithmetic.
    task automatic model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c, output logic v, output logic z);
        logic [W:0]        u;
        logic signed [W:0] s;
        if (op) begin
            u = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            s = $signed({a[W-1], a}) - $signed({b[W-1], b});
        end else begin
            u = {1'b0, a} + {1'b0, b};
            s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        end
        r = u[W-1:0];
        c = u[W];
        v = (s[W] != s[W-1]);
        z = (r == '0);
    endtask

    function automatic logic [W-1:0] rand_wide();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_resp(input string tag, input logic [W-1:0] er, input logic ec,
                              input logic ev, input logic ez);
        check_eq({tag, "_valid"}, W'(resp_valid), W'(1'b1));
        check_eq({tag, "_result"}, resp_result, er);
        check_eq({tag, "_carry"}, W'(resp_carry), W'(ec));
        check_eq({tag, "_overflow"}, W'(resp_overflow), W'(ev));
        check_eq({tag, "_zero"}, W'(resp_zero), W'(ez));
    endtask

    task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] er;
        logic         ec;
        logic         ev;
        logic         ez;
        int           cyc;
        model(op, a, b, er, ec, ev, ez);
        req_op     = op;
        req_a      = a;
        req_b      = b;
        req_valid  = 1'b1;
        resp_ready = (hold == 0);
        cyc = 0;
        while (!req_ready && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, "_req_ready"}, W'(req_ready), W'(1'b1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq({tag, "_busy"}, W'(busy), W'(1'b1));
        cyc = 0;
        while (!resp_valid && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, "_latency"}, W'(cyc), W'(NW));
        check_resp(tag, er, ec, ev, ez);
        if (hold > 0) begin
            req_valid = 1'b1;
            req_op    = ~op;
            req_a     = rand_wide();
            req_b     = rand_wide();
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check_resp({tag, "_hold"}, er, ec, ev, ez);
                check_eq({tag, "_hold_req_ready"}, W'(req_ready), W'(1'b0));
            end
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check_eq({tag, "_after_valid"}, W'(resp_valid), W'(1'b0));
        check_eq({tag, "_after_req_ready"}, W'(req_ready), W'(1'b1));
        check_eq({tag, "_after_busy"}, W'(busy), W'(1'b0));
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] max_pos;
        logic [W-1:0] min_neg;
        logic [W-1:0] chain;
        ones    = '1;
        max_pos = {1'b0, {(W-1){1'b1}}};
        min_neg = {1'b1, {(W-1){1'b0}}};
        chain   = {32'h0000_0000, {(W-32){1'b1}}};

        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_req_ready", W'(req_ready), W'(1'b1));
        check_eq("rst_resp_valid", W'(resp_valid), W'(1'b0));
        check_eq("rst_busy", W'(busy), W'(1'b0));
        check_eq("rst_result", resp_result, '0);
        check_eq("rst_flags", W'({resp_carry, resp_overflow, resp_zero}), W'(3'b000));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op("ones_plus_1", 1'b0, ones, W'(1), 0);
        run_op("zero_minus_1", 1'b1, '0, W'(1), 2);
        run_op("maxpos_plus_1", 1'b0, max_pos, W'(1), 0);
        run_op("minneg_minus_1", 1'b1, min_neg, W'(1), 1);
        run_op("carry_chain", 1'b0, chain, W'(1), 0);
        run_op("backpressure", 1'b1, rand_wide(), rand_wide(), 10);

        // Abort mid-RUN after word 1 has been processed.
        req_op    = 1'b0;
        req_a     = rand_wide();
        req_b     = rand_wide();
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("midrun_busy", W'(busy), W'(1'b1));
        rst_n = 1'b0;
        #1;
        check_eq("midrun_rst_req_ready", W'(req_ready), W'(1'b1));
        check_eq("midrun_rst_busy", W'(busy), W'(1'b0));
        check_eq("midrun_rst_result", resp_result, '0);
        check_eq("midrun_rst_flags", W'({resp_carry, resp_overflow, resp_zero}), W'(3'b000));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("midrun_rst_no_valid", W'(resp_valid), W'(1'b0));
        end
        rst_n = 1'b1;
        run_op("after_rst_5_plus_7", 1'b0, W'(5), W'(7), 0);

        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rop;
            ra  = rand_wide();
            rb  = ($urandom_range(0, 3) == 0) ? ra : rand_wide();
            rop = 1'($urandom_range(0, 1));
            run_op("random", rop, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule
